uart_core_param: RTL and testbench
==================================

// Module: uart_core_param
// PURPOSE
//  Parametrised full-duplex UART: TX and RX engines sharing one on-chip 16x oversampling baud tick.
//  Runtime baud divisor; configurable data/stop bits; valid/ready handshakes on both byte interfaces.
//  RX samples at bit centre with false-start rejection and framing/overrun detection.
//  Drop-in core under the system top level, running on the system clock.
// PARAMETERS
//  DATA_BITS  8   payload bits per frame, legal 5..9, sent LSB first
//  STOP_BITS  1   stop bits transmitted, 1 or 2; RX checks only the first
//  DIV_W      16  width of baud_div
// PORTS
//  clk        in   1          system clock, all logic rising-edge
//  reset      in   1          asynchronous, active-low reset
//  baud_div   in   DIV_W      oversample tick every baud_div+1 clk cycles (tick rate = 16x baud)
//  tx_data    in   DATA_BITS  byte to send
//  tx_valid   in   1          tx_data valid
//  tx_ready   out  1          TX idle, accepts a byte
//  tx_out     out  1          serial line, idles high
//  rx_in      in   1          serial line, asynchronous to clk
//  rx_data    out  DATA_BITS  received byte
//  rx_valid   out  1          rx_data/flags valid, held until consumed
//  rx_ready   in   1          consumer takes rx_data
//  frame_err  out  1          qualifies rx_data: stop sample was 0
//  overrun    out  1          one-clk pulse: frame completed while rx_valid still high
//  parity_odd in   1          (UART_PARITY_EN only) 1 = odd, 0 = even parity
//  parity_err out  1          (UART_PARITY_EN only) qualifies rx_data: parity mismatch
// BEHAVIOUR
//  Reset: tx_out=1, tx_ready=1, rx_valid=0, rx_data=0, all flags 0, FSMs IDLE, tick counter 0.
//  Tick: counter counts 0..baud_div, emits 1-clk tick at wrap; baud_div=0 -> tick every clk.
//   baud_div change takes effect at next wrap; never restarts a frame.
//  Every bit lasts exactly 16 ticks (4-bit per-engine sub-counter).
//  TX FSM IDLE->START->DATA->[PARITY]->STOP->IDLE.
//   Transfer on tx_valid&&tx_ready: tx_data latched, tx_ready=0 next clk; START entered at next tick.
//   tx_out registered; DATA shifts LSB first; STOP holds 1 for STOP_BITS*16 ticks.
//   tx_ready=1 again in the clk after the last stop tick; back-to-back frames without an idle bit.
//   tx_data changes while tx_ready=0 are ignored.
//  RX: rx_in through a 2-flop synchroniser (2 clk latency), reset value 1.
//   FSM IDLE->START->DATA->[PARITY]->STOP->IDLE.
//   IDLE: falling edge of synced line -> START, sub-counter cleared.
//   START: at sub-count 7 (bit centre) line=1 -> false start, back to IDLE, no output.
//   DATA/PARITY/STOP sampled at sub-count 7 of each bit, i.e. every 16 ticks from start centre.
//   STOP: on stop sample, rx_data, frame_err, parity_err updated, rx_valid=1, same clk -> IDLE.
//    frame_err=1 if stop sample 0; the byte is still delivered.
//    Hunting for the next start begins immediately after the stop sample (half-bit early).
//   rx_valid&&rx_ready: rx_valid drops next clk. rx_valid and rx_ready both high while a new
//    frame completes -> new frame loaded, rx_valid stays 1, no overrun.
//   Frame completes with rx_valid=1 and rx_ready=0 -> new frame dropped, old data kept, overrun pulses.
//  Line held low (break): frame_err frame delivered, then RX waits in IDLE for the line to go high.
//  Reset mid-frame: both FSMs abort immediately; tx_out=1 asynchronously.
// CONFIGURATION
//  UART_PARITY_EN defined: one parity bit after DATA on TX and RX, polarity from parity_odd
//   (even: XOR of data^parity = 0); parity_err flags the delivered byte.
//   parity_odd is sampled at the TX handshake and at the RX start-bit centre.
//  Not defined: no PARITY state, no parity_odd/parity_err ports; frame = start+DATA_BITS+stop.
// STRUCTURE
//  Package uart_pkg: TX/RX state enum localparams, OVERSAMPLE=16, SAMPLE_POINT=7.
//  Sub-module uart_baud_tick (clk, reset, baud_div -> tick): the one natural split.
//  TX and RX FSMs stay inline in uart_core_param.
// TESTING
//  baud_div=0, tx 0xA5 8N1 -> tx_out 0,1,0,1,0,0,1,0,1,1 with each bit 16 clk;
//   tx_ready low for 160 clk.
//  tx_out looped to rx_in, send 0x00,0xFF,0x3C back-to-back -> three rx_valid with the same data,
//   frame_err=0.
//  rx_in low pulse of 5 ticks then high -> no rx_valid, RX back in IDLE, next valid frame received.
//  Frame 0x55 with stop bit forced 0 -> rx_valid=1, rx_data=0x55, frame_err=1.
//  rx_ready=0, two frames 0x11,0x22 -> rx_data stays 0x11, overrun one pulse at the second stop.
//  UART_PARITY_EN, parity_odd=0, rx 0x07 with parity bit 0 -> parity_err=1;
//   with parity bit 1 -> parity_err=0.
//  reset asserted mid-DATA -> tx_out=1, tx_ready=1 after release, rx_valid=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and FSM state types for the UART core.
// Parity states are used only when UART_PARITY_EN is defined.
package uart_pkg;

   localparam int unsigned OVERSAMPLE   = 16;
   localparam int unsigned SAMPLE_POINT = 7;
   localparam int unsigned SUB_W        = 4;
   localparam int unsigned BIT_W        = 4;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_e;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rx_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// 16x oversample tick generator: one-clk tick every baud_div+1 clocks.
// A new baud_div is picked up only at a counter wrap.
module uart_baud_tick #(
   parameter int unsigned DIV_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [DIV_W-1:0] baud_div,
   output logic             tick
);

   logic [DIV_W-1:0] cnt_q;
   logic [DIV_W-1:0] div_q;
   logic             wrap_c;

   assign wrap_c = (cnt_q == div_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
         div_q <= '0;
         tick  <= 1'b0;
      end else begin
         tick <= wrap_c;
         if (wrap_c) begin
            cnt_q <= '0;
            div_q <= baud_div;
         end else begin
            cnt_q <= cnt_q + DIV_W'(1);
         end
      end
   end

endmodule

// File: rtl/uart_core_param.sv
// Full-duplex UART core: TX and RX FSMs sharing one 16x oversample tick.
// Define UART_PARITY_EN to add a parity bit (parity_odd / parity_err ports).
module uart_core_param
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned STOP_BITS = 1,
   parameter int unsigned DIV_W     = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DIV_W-1:0]     baud_div,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx_out,
   input  logic                 rx_in,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 overrun
`ifdef UART_PARITY_EN
   ,
   input  logic                 parity_odd,
   output logic                 parity_err
`endif
);

   logic tick;

   uart_baud_tick #(.DIV_W(DIV_W)) u_baud_tick (
      .clk      (clk),
      .reset    (reset),
      .baud_div (baud_div),
      .tick     (tick)
   );

   // ---------------- TX ----------------
   tx_state_e            tx_state_q, tx_state_d;
   logic [SUB_W-1:0]     tx_sub_q, tx_sub_d;
   logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
   logic                 tx_stop_q, tx_stop_d;
   logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
   logic                 tx_ready_d, tx_out_d;
   logic                 tx_bit_end_c;
`ifdef UART_PARITY_EN
   logic                 tx_par_q, tx_par_d;
`endif

   assign tx_bit_end_c = tick && (tx_sub_q == SUB_W'(OVERSAMPLE - 1));

   always_comb begin
      tx_state_d = tx_state_q;
      tx_sub_d   = tx_sub_q;
      tx_bit_d   = tx_bit_q;
      tx_stop_d  = tx_stop_q;
      tx_shift_d = tx_shift_q;
      tx_ready_d = tx_ready;
      tx_out_d   = tx_out;
`ifdef UART_PARITY_EN
      tx_par_d   = tx_par_q;
`endif
      if (tx_state_q != TX_IDLE && tick) tx_sub_d = tx_sub_q + SUB_W'(1);

      case (tx_state_q)
         TX_IDLE: begin
            if (tx_valid && tx_ready) begin
               tx_shift_d = tx_data;
               tx_ready_d = 1'b0;
`ifdef UART_PARITY_EN
               tx_par_d   = (^tx_data) ^ parity_odd;
`endif
            end
            // The tick coinciding with the handshake already starts the frame.
            if (tick && (tx_valid || !tx_ready)) begin
               tx_state_d = TX_START;
               tx_sub_d   = '0;
               tx_out_d   = 1'b0;
            end
         end
         TX_START: begin
            if (tx_bit_end_c) begin
               tx_state_d = TX_DATA;
               tx_bit_d   = '0;
               tx_out_d   = tx_shift_q[0];
            end
         end
         TX_DATA: begin
            if (tx_bit_end_c) begin
               if (tx_bit_q == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                  tx_state_d = TX_PARITY;
                  tx_out_d   = tx_par_q;
`else
                  tx_state_d = TX_STOP;
                  tx_stop_d  = 1'b0;
                  tx_out_d   = 1'b1;
`endif
               end else begin
                  tx_bit_d   = tx_bit_q + BIT_W'(1);
                  tx_shift_d = tx_shift_q >> 1;
                  tx_out_d   = tx_shift_q[1];
               end
            end
         end
`ifdef UART_PARITY_EN
         TX_PARITY: begin
            if (tx_bit_end_c) begin
               tx_state_d = TX_STOP;
               tx_stop_d  = 1'b0;
               tx_out_d   = 1'b1;
            end
         end
`endif
         TX_STOP: begin
            if (tx_bit_end_c) begin
               if (tx_stop_q == 1'(STOP_BITS - 1)) begin
                  tx_state_d = TX_IDLE;
                  tx_ready_d = 1'b1;
               end else begin
                  tx_stop_d = 1'b1;
               end
            end
         end
         default: begin
            tx_state_d = TX_IDLE;
            tx_ready_d = 1'b1;
            tx_out_d   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_state_q <= TX_IDLE;
         tx_sub_q   <= '0;
         tx_bit_q   <= '0;
         tx_stop_q  <= 1'b0;
         tx_shift_q <= '0;
         tx_ready   <= 1'b1;
         tx_out     <= 1'b1;
`ifdef UART_PARITY_EN
         tx_par_q   <= 1'b0;
`endif
      end else begin
         tx_state_q <= tx_state_d;
         tx_sub_q   <= tx_sub_d;
         tx_bit_q   <= tx_bit_d;
         tx_stop_q  <= tx_stop_d;
         tx_shift_q <= tx_shift_d;
         tx_ready   <= tx_ready_d;
         tx_out     <= tx_out_d;
`ifdef UART_PARITY_EN
         tx_par_q   <= tx_par_d;
`endif
      end
   end

   // ---------------- RX ----------------
   logic [1:0]           sync_q;
   logic                 rx_prev_q;
   logic                 rx_s;
   rx_state_e            rx_state_q, rx_state_d;
   logic [SUB_W-1:0]     rx_sub_q, rx_sub_d;
   logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
   logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
   logic [DATA_BITS-1:0] rx_data_d;
   logic                 rx_valid_d, frame_err_d, overrun_d;
   logic                 rx_sample_c;
`ifdef UART_PARITY_EN
   logic                 rx_podd_q, rx_podd_d;
   logic                 rx_perr_q, rx_perr_d;
   logic                 parity_err_d;
`endif

   assign rx_s        = sync_q[1];
   assign rx_sample_c = tick && (rx_sub_q == SUB_W'(SAMPLE_POINT));

   always_comb begin
      rx_state_d  = rx_state_q;
      rx_sub_d    = rx_sub_q;
      rx_bit_d    = rx_bit_q;
      rx_shift_d  = rx_shift_q;
      rx_data_d   = rx_data;
      rx_valid_d  = rx_valid;
      frame_err_d = frame_err;
      overrun_d   = 1'b0;
`ifdef UART_PARITY_EN
      rx_podd_d    = rx_podd_q;
      rx_perr_d    = rx_perr_q;
      parity_err_d = parity_err;
`endif
      if (rx_valid && rx_ready) rx_valid_d = 1'b0;
      if (rx_state_q != RX_IDLE && tick) rx_sub_d = rx_sub_q + SUB_W'(1);

      case (rx_state_q)
         RX_IDLE: begin
            // Edge-triggered so a held-low line (break) is not re-taken as a start.
            if (rx_prev_q && !rx_s) begin
               rx_state_d = RX_START;
               rx_sub_d   = '0;
            end
         end
         RX_START: begin
            if (rx_sample_c) begin
               if (rx_s) begin
                  rx_state_d = RX_IDLE;
               end else begin
                  rx_state_d = RX_DATA;
                  rx_bit_d   = '0;
`ifdef UART_PARITY_EN
                  rx_podd_d  = parity_odd;
`endif
               end
            end
         end
         RX_DATA: begin
            if (rx_sample_c) begin
               rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
               if (rx_bit_q == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                  rx_state_d = RX_PARITY;
`else
                  rx_state_d = RX_STOP;
`endif
               end else begin
                  rx_bit_d = rx_bit_q + BIT_W'(1);
               end
            end
         end
`ifdef UART_PARITY_EN
         RX_PARITY: begin
            if (rx_sample_c) begin
               rx_perr_d  = rx_s ^ (^rx_shift_q) ^ rx_podd_q;
               rx_state_d = RX_STOP;
            end
         end
`endif
         RX_STOP: begin
            if (rx_sample_c) begin
               rx_state_d = RX_IDLE;
               if (rx_valid && !rx_ready) begin
                  overrun_d = 1'b1;
               end else begin
                  rx_data_d   = rx_shift_q;
                  frame_err_d = !rx_s;
                  rx_valid_d  = 1'b1;
`ifdef UART_PARITY_EN
                  parity_err_d = rx_perr_q;
`endif
               end
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q     <= 2'b11;
         rx_prev_q  <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_sub_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
`ifdef UART_PARITY_EN
         rx_podd_q  <= 1'b0;
         rx_perr_q  <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         sync_q     <= {sync_q[0], rx_in};
         rx_prev_q  <= sync_q[1];
         rx_state_q <= rx_state_d;
         rx_sub_q   <= rx_sub_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         rx_data    <= rx_data_d;
         rx_valid   <= rx_valid_d;
         frame_err  <= frame_err_d;
         overrun    <= overrun_d;
`ifdef UART_PARITY_EN
         rx_podd_q  <= rx_podd_d;
         rx_perr_q  <= rx_perr_d;
         parity_err <= parity_err_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_core_param.sv
// Self-checking bench for uart_core_param (8 data bits, 1 stop bit).
// Also covers the parity build when UART_PARITY_EN is defined.
module tb_uart_core_param;

   localparam int unsigned DIV_W = 16;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic [DIV_W-1:0] baud_div = '0;
   logic [7:0]       tx_data = 8'h00;
   logic             tx_valid = 1'b0;
   logic             tx_ready, tx_out;
   logic             rx_in;
   logic             rx_drv = 1'b1;
   logic             loop_en = 1'b0;
   logic [7:0]       rx_data;
   logic             rx_valid;
   logic             rx_ready = 1'b0;
   logic             frame_err, overrun;
`ifdef UART_PARITY_EN
   logic             parity_odd = 1'b0;
   logic             parity_err;
   logic             par_flip = 1'b0;
`endif

   typedef struct packed {
      logic [7:0] data;
      logic       ferr;
      logic       perr;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   errors  = 0;

   always #5 clk = ~clk;
   assign rx_in = loop_en ? tx_out : rx_drv;

   uart_core_param #(.DATA_BITS(8), .STOP_BITS(1), .DIV_W(DIV_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .baud_div  (baud_div),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .tx_out    (tx_out),
      .rx_in     (rx_in),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overrun   (overrun)
`ifdef UART_PARITY_EN
      ,
      .parity_odd(parity_odd),
      .parity_err(parity_err)
`endif
   );

   // Bit-bang one frame on rx_drv at the current baud, then one idle bit.
   task automatic send_rx(input logic [7:0] d, input logic stop);
      int bt;
      bt = 16 * (int'(baud_div) + 1);
      rx_drv = 1'b0;
      repeat (bt) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_drv = d[i];
         repeat (bt) @(negedge clk);
      end
`ifdef UART_PARITY_EN
      rx_drv = (^d) ^ parity_odd ^ par_flip;
      repeat (bt) @(negedge clk);
`endif
      rx_drv = stop;
      repeat (bt) @(negedge clk);
      rx_drv = 1'b1;
      repeat (bt) @(negedge clk);
   endtask

   task automatic consume();
      @(negedge clk) rx_ready = 1'b1;
      @(negedge clk) rx_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      vectors++; if (tx_out !== 1'b1)    begin errors++; $display("FAIL reset_tx_out: got %b want 1", tx_out); end
      vectors++; if (tx_ready !== 1'b1)  begin errors++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
      vectors++; if (rx_valid !== 1'b0)  begin errors++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
      vectors++; if (rx_data !== 8'h00)  begin errors++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
      vectors++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
      vectors++; if (overrun !== 1'b0)   begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
      @(negedge clk) reset = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_tx_frame();
      logic [10:0] expv;
      int          nb, k, low;
      logic [7:0]  d;
      d = 8'hA5;
      expv = '1;
      expv[0] = 1'b0;
      for (int i = 0; i < 8; i++) expv[i+1] = d[i];
      nb = 10;
`ifdef UART_PARITY_EN
      expv[9] = (^d) ^ parity_odd;
      nb = 11;
`endif
      @(negedge clk);
      tx_data = d; tx_valid = 1'b1;
      @(posedge clk);
      #1 tx_valid = 1'b0; tx_data = 8'hFF;
      k = 0; low = 0;
      while (k < 400) begin
         @(negedge clk);
         if (tx_ready) break;
         if (k % 16 == 8) begin
            vectors++;
            if (tx_out !== expv[k/16]) begin errors++; $display("FAIL tx_bit%0d: got %b want %b", k/16, tx_out, expv[k/16]); end
         end
         low++; k++;
      end
      vectors++; if (low != nb * 16) begin errors++; $display("FAIL tx_ready_low: got %0d clk want %0d", low, nb * 16); end
      vectors++; if (tx_out !== 1'b1) begin errors++; $display("FAIL tx_idle_line: got %b want 1", tx_out); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] bytes [3];
      bytes = '{8'h00, 8'hFF, 8'h3C};
      loop_en = 1'b1; rx_ready = 1'b1;
      for (int i = 0; i < 3; i++) sb.push_back('{data: bytes[i], ferr: 1'b0, perr: 1'b0});
      fork
         begin
            for (int i = 0; i < 3; i++) begin
               int n;
               n = 0;
               @(negedge clk);
               while (!tx_ready && n < 3000) begin @(negedge clk); n++; end
               tx_data = bytes[i]; tx_valid = 1'b1;
               @(posedge clk);
               #1 tx_valid = 1'b0;
            end
         end
         begin
            for (int i = 0; i < 3; i++) begin
               int   n;
               exp_t e;
               n = 0;
               @(negedge clk);
               while (!rx_valid && n < 3000) begin @(negedge clk); n++; end
               e = sb.pop_front();
               vectors++; if (rx_valid !== 1'b1)   begin errors++; $display("FAIL b2b_valid%0d: got %b want 1", i, rx_valid); end
               vectors++; if (rx_data !== e.data)  begin errors++; $display("FAIL b2b_data%0d: got %h want %h", i, rx_data, e.data); end
               vectors++; if (frame_err !== e.ferr) begin errors++; $display("FAIL b2b_ferr%0d: got %b want %b", i, frame_err, e.ferr); end
            end
         end
      join
      repeat (40) @(negedge clk);
      loop_en = 1'b0; rx_ready = 1'b0;
   endtask

   task automatic test_false_start();
      exp_t e;
      int   seen;
      baud_div = 16'd3;
      repeat (40) @(negedge clk);
      rx_drv = 1'b0;
      repeat (20) @(negedge clk);
      rx_drv = 1'b1;
      seen = 0;
      repeat (300) begin @(negedge clk); if (rx_valid) seen++; end
      vectors++; if (seen != 0) begin errors++; $display("FAIL false_start_valid: got %0d cycles want 0", seen); end
      sb.push_back('{data: 8'h5A, ferr: 1'b0, perr: 1'b0});
      send_rx(8'h5A, 1'b1);
      e = sb.pop_front();
      vectors++; if (rx_valid !== 1'b1)    begin errors++; $display("FAIL after_false_valid: got %b want 1", rx_valid); end
      vectors++; if (rx_data !== e.data)   begin errors++; $display("FAIL after_false_data: got %h want %h", rx_data, e.data); end
      vectors++; if (frame_err !== e.ferr) begin errors++; $display("FAIL after_false_ferr: got %b want %b", frame_err, e.ferr); end
      consume();
      vectors++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL consume_drop: got %b want 0", rx_valid); end
   endtask

   task automatic test_frame_err();
      exp_t e;
      sb.push_back('{data: 8'h55, ferr: 1'b1, perr: 1'b0});
      send_rx(8'h55, 1'b0);
      e = sb.pop_front();
      vectors++; if (rx_valid !== 1'b1)    begin errors++; $display("FAIL ferr_valid: got %b want 1", rx_valid); end
      vectors++; if (rx_data !== e.data)   begin errors++; $display("FAIL ferr_data: got %h want %h", rx_data, e.data); end
      vectors++; if (frame_err !== e.ferr) begin errors++; $display("FAIL ferr_flag: got %b want %b", frame_err, e.ferr); end
      consume();
   endtask

   task automatic test_overrun();
      exp_t e;
      int   pulses;
      logic done;
      pulses = 0; done = 1'b0;
      sb.push_back('{data: 8'h11, ferr: 1'b0, perr: 1'b0});
      fork
         begin
            send_rx(8'h11, 1'b1);
            send_rx(8'h22, 1'b1);
            done = 1'b1;
         end
         begin
            while (!done) begin @(negedge clk); if (overrun) pulses++; end
         end
      join
      e = sb.pop_front();
      vectors++; if (pulses != 1)         begin errors++; $display("FAIL overrun_pulses: got %0d want 1", pulses); end
      vectors++; if (rx_valid !== 1'b1)   begin errors++; $display("FAIL overrun_valid: got %b want 1", rx_valid); end
      vectors++; if (rx_data !== e.data)  begin errors++; $display("FAIL overrun_data: got %h want %h", rx_data, e.data); end
      consume();
   endtask

`ifdef UART_PARITY_EN
   task automatic test_parity();
      exp_t e;
      parity_odd = 1'b0;
      for (int i = 0; i < 2; i++) begin
         par_flip = (i == 0);
         sb.push_back('{data: 8'h07, ferr: 1'b0, perr: par_flip});
         send_rx(8'h07, 1'b1);
         e = sb.pop_front();
         vectors++; if (rx_data !== e.data)    begin errors++; $display("FAIL parity_data%0d: got %h want %h", i, rx_data, e.data); end
         vectors++; if (parity_err !== e.perr) begin errors++; $display("FAIL parity_err%0d: got %b want %b", i, parity_err, e.perr); end
         consume();
      end
      par_flip = 1'b0;
   endtask
`endif

   task automatic test_reset_mid();
      int seen;
      baud_div = '0;
      repeat (40) @(negedge clk);
      loop_en = 1'b1;
      tx_data = 8'h96; tx_valid = 1'b1;
      @(posedge clk);
      #1 tx_valid = 1'b0;
      repeat (60) @(negedge clk);
      reset = 1'b0;
      #1;
      vectors++; if (tx_out !== 1'b1)   begin errors++; $display("FAIL midreset_tx_out: got %b want 1", tx_out); end
      vectors++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL midreset_rx_valid: got %b want 0", rx_valid); end
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      vectors++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL postreset_tx_ready: got %b want 1", tx_ready); end
      seen = 0;
      repeat (300) begin @(negedge clk); if (rx_valid) seen++; end
      vectors++; if (seen != 0) begin errors++; $display("FAIL postreset_rx_valid: got %0d cycles want 0", seen); end
      vectors++; if (tx_out !== 1'b1) begin errors++; $display("FAIL postreset_tx_out: got %b want 1", tx_out); end
      loop_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_tx_frame();
      test_back_to_back();
      test_false_start();
      test_frame_err();
      test_overrun();
`ifdef UART_PARITY_EN
      test_parity();
`endif
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #2000000;
      errors++;
      $display("FAIL watchdog: simulation still running at time %0t", $time);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
